// File: rtl/rv32_muldiv_exec_stage.sv
// rv32_muldiv_exec_stage
//   Execute-stage unit for the RV32M extension. Multiplies complete in
//   MUL_CYCLES cycles; divides use a restoring radix-2 divider (one quotient
//   bit per cycle). Results are registered into the exec->mem buffer.
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   in_valid/in_op/...   instruction from upstream (held stable while stall=1)
//   mem_stall            memory stage stall: freezes the whole unit
//   stall                upstream must hold its inputs
//   out_valid/pc/rd/res  exec->mem buffer (all zero when it holds a bubble)
//   dbg_state            current FSM state, for observation only
//
// Handshake: an instruction with in_valid=1 is consumed at the first rising
// edge where stall=0; until then upstream holds every in_* stable. The
// output buffer loads on every edge with mem_stall=0 and holds otherwise.
module rv32_muldiv_exec_stage #(
  parameter int MUL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_pc,
  input  logic        mem_stall,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [4:0]  out_rd,
  output logic [31:0] out_result,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_DIV      = 2'd2,
    S_FINISH   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        is_rem_q, is_rem_d;
  logic        neg_q_q, neg_q_d;
  logic        neg_r_q, neg_r_d;
  logic [31:0] dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
  logic [31:0] dvs_q, dvs_d;   // divisor magnitude
  logic [31:0] rem_q, rem_d;   // partial remainder magnitude
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic [31:0] out_result_q, out_result_d;

  // Multiply: sign-extend to 64 bits so a plain 64-bit product is exact.
  logic        mul_sa, mul_sb;
  logic [63:0] mul_a, mul_b, mul_p;
  logic [31:0] mul_res;

  always_comb begin
    mul_sa  = (in_op[1:0] == 2'b01) || (in_op[1:0] == 2'b10);
    mul_sb  = (in_op[1:0] == 2'b01);
    mul_a   = {{32{mul_sa & in_rs1[31]}}, in_rs1};
    mul_b   = {{32{mul_sb & in_rs2[31]}}, in_rs2};
    mul_p   = mul_a * mul_b;
    mul_res = (in_op[1:0] == 2'b00) ? mul_p[31:0] : mul_p[63:32];
  end

  // Divide operand decode and single-cycle special cases.
  logic        div_signed, div_rem, a_neg, b_neg, div_zero, div_ovf;
  logic [31:0] abs_a, abs_b, special_res;

  always_comb begin
    div_signed  = ~in_op[0];
    div_rem     = in_op[1];
    a_neg       = div_signed & in_rs1[31];
    b_neg       = div_signed & in_rs2[31];
    abs_a       = a_neg ? -in_rs1 : in_rs1;
    abs_b       = b_neg ? -in_rs2 : in_rs2;
    div_zero    = (in_rs2 == 32'd0);
    div_ovf     = div_signed && (in_rs1 == 32'h8000_0000) && (in_rs2 == 32'hFFFF_FFFF);
    if (div_zero) special_res = div_rem ? in_rs1 : 32'hFFFF_FFFF;
    else          special_res = div_rem ? 32'd0  : 32'h8000_0000;
  end

  // One restoring step: shift in the next dividend bit, try to subtract.
  logic [32:0] rem_sh, diff;
  logic        q_bit;
  logic [31:0] div_res;

  always_comb begin
    rem_sh  = {rem_q, dvd_q[31]};
    diff    = rem_sh - {1'b0, dvs_q};
    q_bit   = ~diff[32];
    if (is_rem_q) div_res = neg_r_q ? -rem_q : rem_q;
    else          div_res = neg_q_q ? -dvd_q : dvd_q;
  end

  logic        busy, done;
  logic [31:0] res;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    is_rem_d = is_rem_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    busy     = 1'b0;
    done     = 1'b0;
    res      = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (!in_op[2]) begin
            if (MUL_CYCLES == 1) begin
              done = 1'b1;
              res  = mul_res;
            end else begin
              busy     = 1'b1;
              is_div_d = 1'b0;
              cnt_d    = 5'(MUL_CYCLES - 2);
              // With two cycles the accept cycle is the only wait cycle.
              state_d  = (MUL_CYCLES == 2) ? S_FINISH : S_MUL_WAIT;
            end
          end else if (div_zero || div_ovf) begin
            done = 1'b1;
            res  = special_res;
          end else begin
            busy     = 1'b1;
            is_div_d = 1'b1;
            is_rem_d = div_rem;
            neg_q_d  = a_neg ^ b_neg;
            neg_r_d  = a_neg;
            dvd_d    = abs_a;
            dvs_d    = abs_b;
            rem_d    = 32'd0;
            cnt_d    = 5'd0;
            state_d  = S_DIV;
          end
        end
      end
      S_MUL_WAIT: begin
        // Leave when the count reaches zero so the buffer loads exactly
        // MUL_CYCLES edges after accept.
        busy  = 1'b1;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = S_FINISH;
      end
      S_DIV: begin
        busy  = 1'b1;
        rem_d = q_bit ? diff[31:0] : rem_sh[31:0];
        dvd_d = {dvd_q[30:0], q_bit};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FINISH;
      end
      default: begin
        done    = 1'b1;
        res     = is_div_q ? div_res : mul_res;
        state_d = S_IDLE;
      end
    endcase
    out_valid_d  = done;
    out_pc_d     = done ? in_pc : 32'd0;
    out_rd_d     = done ? in_rd : 5'd0;
    out_result_d = res;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= 5'd0;
      is_div_q     <= 1'b0;
      is_rem_q     <= 1'b0;
      neg_q_q      <= 1'b0;
      neg_r_q      <= 1'b0;
      dvd_q        <= 32'd0;
      dvs_q        <= 32'd0;
      rem_q        <= 32'd0;
      out_valid_q  <= 1'b0;
      out_pc_q     <= 32'd0;
      out_rd_q     <= 5'd0;
      out_result_q <= 32'd0;
    end else if (!mem_stall) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_div_q     <= is_div_d;
      is_rem_q     <= is_rem_d;
      neg_q_q      <= neg_q_d;
      neg_r_q      <= neg_r_d;
      dvd_q        <= dvd_d;
      dvs_q        <= dvs_d;
      rem_q        <= rem_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_rd_q     <= out_rd_d;
      out_result_q <= out_result_d;
    end
  end

  assign stall      = mem_stall | busy;
  assign out_valid  = out_valid_q;
  assign out_pc     = out_pc_q;
  assign out_rd     = out_rd_q;
  assign out_result = out_result_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rv32_muldiv_exec_stage.sv
module tb_rv32_muldiv_exec_stage;

  localparam int W = 69;  // {pc, rd, result}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn1, resetn3;
  logic        in_valid;
  logic [2:0]  in_op;
  logic [31:0] in_rs1, in_rs2, in_pc;
  logic [4:0]  in_rd;
  logic        mem_stall;

  logic        stall1, out_valid1, stall3, out_valid3;
  logic [31:0] out_pc1, out_result1, out_pc3, out_result3;
  logic [4:0]  out_rd1, out_rd3;
  logic [1:0]  dbg1, dbg3;

  rv32_muldiv_exec_stage #(.MUL_CYCLES(1)) dut1 (
    .clk(clk), .resetn(resetn1), .in_valid(in_valid), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_pc(in_pc),
    .mem_stall(mem_stall), .stall(stall1), .out_valid(out_valid1),
    .out_pc(out_pc1), .out_rd(out_rd1), .out_result(out_result1),
    .dbg_state(dbg1)
  );

  rv32_muldiv_exec_stage #(.MUL_CYCLES(3)) dut3 (
    .clk(clk), .resetn(resetn3), .in_valid(in_valid), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_pc(in_pc),
    .mem_stall(mem_stall), .stall(stall3), .out_valid(out_valid3),
    .out_pc(out_pc3), .out_rd(out_rd3), .out_result(out_result3),
    .dbg_state(dbg3)
  );

  logic sel3;
  logic act_stall, act_out_valid;
  logic [W-1:0] act_out;
  logic [1:0] act_dbg;
  assign act_stall     = sel3 ? stall3 : stall1;
  assign act_out_valid = sel3 ? out_valid3 : out_valid1;
  assign act_out       = sel3 ? {out_pc3, out_rd3, out_result3} : {out_pc1, out_rd1, out_result1};
  assign act_dbg       = sel3 ? dbg3 : dbg1;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;
  logic ms_prev = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) ms_prev <= mem_stall;

  // A fresh load happens only on an edge without mem_stall.
  always @(negedge clk) begin
    if (mon_en) begin
      if (act_out_valid === 1'b1) begin
        if (!ms_prev) begin
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_output: observed=%0h expected=none", act_out);
          end
          if (exp_q.size() != 0) check("result", act_out, exp_q.pop_front());
        end
      end else begin
        check("bubble", act_out, '0);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic signed [31:0] sa, sb;
    logic [31:0] r;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    ea  = {{32{((op == 3'b001) || (op == 3'b010)) & a[31]}}, a};
    eb  = {{32{(op == 3'b001) & b[31]}}, b};
    p   = ea * eb;
    r   = 32'd0;
    case (op)
      3'b000: r = p[31:0];
      3'b001, 3'b010, 3'b011: r = p[63:32];
      3'b100: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (ovf) r = 32'h8000_0000;
        else r = sa / sb;
      end
      3'b101: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else r = a / b;
      end
      3'b110: begin
        if (b == 0) r = a;
        else if (ovf) r = 32'd0;
        else r = sa % sb;
      end
      default: begin
        if (b == 0) r = a;
        else r = a % b;
      end
    endcase
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Presents one instruction, counts stall cycles until it is consumed.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_stall,
                        input int ms_at, input int ms_len, input bit chk_prev);
    int c;
    int nst;
    logic done;
    logic [4:0] rd;
    logic [31:0] pc;
    rd = 5'($urandom_range(1, 31));
    pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_rd = rd; in_pc = pc;
    exp_q.push_back({pc, rd, exp_res});
    c = 0; nst = 0; done = 1'b0;
    while (!done && c < 200) begin
      mem_stall = (c >= ms_at) && (c < ms_at + ms_len);
      @(negedge clk);
      if (chk_prev && c == 0) check("b2b_valid", W'(act_out_valid), W'(1'b1));
      if (act_stall) nst++;
      else done = 1'b1;
      @(posedge clk); #1;
      c++;
    end
    mem_stall = 1'b0;
    in_valid = 1'b0;
    in_rs1 = $urandom; in_rs2 = $urandom;
    check("accept_timeout", W'(done), W'(1'b1));
    check("stall_cycles", W'(nst), W'(exp_stall));
  endtask

  task automatic expect_valid();
    @(negedge clk);
    check("valid_latency", W'(act_out_valid), W'(1'b1));
    @(posedge clk); #1;
  endtask

  task automatic run_random(input int n, input int mul_stall);
    logic [2:0] op;
    logic [31:0] a, b;
    int es;
    for (int i = 0; i < n; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom >> $urandom_range(0, 28));
      if (!op[2]) es = mul_stall;
      else if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) es = 0;
      else es = 33;
      run_op(op, a, b, ref_model(op, a, b), es, -1, 0, 1'b0);
      expect_valid();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    resetn1 = 1'b0; resetn3 = 1'b0; sel3 = 1'b0;
    in_valid = 1'b0; in_op = 3'd0; in_rs1 = 32'd0; in_rs2 = 32'd0;
    in_rd = 5'd0; in_pc = 32'd0; mem_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn1 = 1'b1;
    @(negedge clk);
    check("rst_out", {out_pc1, out_rd1, out_result1}, '0);
    check("rst_valid", W'(out_valid1), '0);
    check("rst_stall", W'(stall1), '0);
    check("rst_state", W'(dbg1), '0);
    check("rst_out3", {W'(out_valid3), W'(dbg3)} , '0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // MUL_CYCLES=1 multiplies
    run_op(3'b000, 32'd7, 32'd6, 32'd42, 0, -1, 0, 1'b0);                      expect_valid();
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, -1, 0, 1'b0); expect_valid();
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, -1, 0, 1'b0); expect_valid();
    run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0, -1, 0, 1'b0);        expect_valid();

    // Iterative divides
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, -1, 0, 1'b0); expect_valid();
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, -1, 0, 1'b0); expect_valid();
    run_op(3'b101, 32'd100, 32'd7, 32'd14, 33, -1, 0, 1'b0);              expect_valid();
    run_op(3'b111, 32'd100, 32'd7, 32'd2, 33, -1, 0, 1'b0);               expect_valid();

    // Single-cycle special cases
    run_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, -1, 0, 1'b0);                 expect_valid();
    run_op(3'b110, 32'd5, 32'd0, 32'd5, 0, -1, 0, 1'b0);                         expect_valid();
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, -1, 0, 1'b0); expect_valid();
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, -1, 0, 1'b0);         expect_valid();

    // mem_stall during the divide, then while the result sits in the buffer
    run_op(3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 37, 10, 4, 1'b0);
    mem_stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("hold_valid", W'(act_out_valid), W'(1'b1));
      check("hold_result", W'(act_out[31:0]), W'(32'hFFFF_FFF2));
      check("hold_stall", W'(act_stall), W'(1'b1));
      @(posedge clk); #1;
    end
    mem_stall = 1'b0;
    @(negedge clk);
    check("release_valid", W'(act_out_valid), W'(1'b1));
    @(posedge clk); #1;

    // Reset in the middle of a divide
    in_valid = 1'b1; in_op = 3'b100; in_rs1 = 32'd1000; in_rs2 = 32'd3;
    in_rd = 5'd9; in_pc = 32'h100;
    repeat (15) @(posedge clk);
    #1 resetn1 = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1 resetn1 = 1'b1;
    @(negedge clk);
    check("abort_out", {W'(out_valid1), W'(out_pc1), W'(out_rd1), W'(out_result1)}, '0);
    check("abort_stall", W'(stall1), '0);
    check("abort_state", W'(dbg1), '0);
    @(posedge clk); #1;
    run_op(3'b000, 32'd3, 32'd3, 32'd9, 0, -1, 0, 1'b0); expect_valid();

    run_random(5, 0);

    // MUL_CYCLES=3 instance
    resetn1 = 1'b0; sel3 = 1'b1; resetn3 = 1'b1;
    @(negedge clk);
    check("rst3_state", W'(dbg3), '0);
    @(posedge clk); #1;
    run_op(3'b000, 32'd2, 32'd5, 32'd10, 2, -1, 0, 1'b0);
    run_op(3'b101, 32'd9, 32'd3, 32'd3, 33, -1, 0, 1'b1);
    expect_valid();
    run_random(5, 2);

    repeat (3) @(posedge clk);
    check("queue_drain", W'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
